// File: rtl/mc_controller.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing, strobe decode,
// immediate-format select and retired-instruction counter.
module mc_controller (
  input  logic        clk,
  input  logic        rstn,
  output logic        ireq,
  input  logic        iack,
  input  logic [31:0] irdata,
  output logic [31:0] instout,
  output logic [2:0]  imgsel,
  output logic        dmreq,
  input  logic        dmack,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic [1:0]  wbsel,
  input  logic        brtaken,
  output logic        pcwrite,
  output logic [1:0]  pcsel,
  output logic        retire,
  output logic [31:0] instret,
  output logic [2:0]  state,
  output logic        err
);

  localparam logic [2:0] StFetch  = 3'b000;
  localparam logic [2:0] StDecode = 3'b001;
  localparam logic [2:0] StExec   = 3'b010;
  localparam logic [2:0] StMem    = 3'b011;
  localparam logic [2:0] StWb     = 3'b100;
  localparam logic [2:0] StErr    = 3'b111;

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q;
  logic [2:0]  imgsel_q, imgsel_d;
  logic [31:0] instret_q;
  logic        err_q;

  logic [6:0]  opcode;
  logic        is_load, is_store, is_branch, is_jal, is_jalr;
  logic        legal;
  logic [2:0]  imm_fmt;
  logic        store_done;

  assign opcode    = ir_q[6:0];
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);

  always_comb begin
    imm_fmt = 3'b000;
    legal   = 1'b1;
    case (opcode)
      OpImm, OpLoad, OpJalr, OpReg: imm_fmt = 3'b000;
      OpStore:                      imm_fmt = 3'b001;
      OpBranch:                     imm_fmt = 3'b010;
      OpLui, OpAuipc:               imm_fmt = 3'b011;
      OpJal:                        imm_fmt = 3'b100;
      default:                      legal   = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    imgsel_d = imgsel_q;
    case (state_q)
      StFetch:  if (iack) state_d = StDecode;
      StDecode: begin
        if (legal) begin
          state_d  = StExec;
          imgsel_d = imm_fmt;
        end else begin
          state_d = StErr;
        end
      end
      StExec: begin
        if (is_load || is_store) state_d = StMem;
        else if (is_branch)      state_d = StFetch;
        else                     state_d = StWb;
      end
      StMem:    if (dmack) state_d = is_load ? StWb : StFetch;
      StWb:     state_d = StFetch;
      // Unused encodings are treated as a fault, same as an illegal opcode.
      default:  state_d = StErr;
    endcase
  end

  // Store completion is the only strobe allowed to follow dmack combinationally.
  assign store_done = (state_q == StMem) && dmack && is_store;

  always_comb begin
    ireq     = rstn && (state_q == StFetch);
    dmreq    = (state_q == StMem);
    memread  = dmreq && is_load;
    memwrite = dmreq && is_store;
    regwrite = (state_q == StWb);
    retire   = ((state_q == StExec) && is_branch) || store_done || (state_q == StWb);
    pcwrite  = retire;
    pcsel    = 2'b00;
    wbsel    = 2'b00;
    if ((state_q == StExec) && is_branch) begin
      pcsel = {1'b0, brtaken};
    end else if (state_q == StWb) begin
      if (is_jal)       pcsel = 2'b01;
      else if (is_jalr) pcsel = 2'b10;
      if (is_load)                wbsel = 2'b01;
      else if (is_jal || is_jalr) wbsel = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      imgsel_q  <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      imgsel_q <= imgsel_d;
      if ((state_q == StFetch) && iack) ir_q <= irdata;
      if (retire) instret_q <= instret_q + 32'd1;
      if (state_d == StErr) err_q <= 1'b1;
    end
  end

  assign instout = ir_q;
  assign imgsel  = imgsel_q;
  assign instret = instret_q;
  assign state   = state_q;
  assign err     = err_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
REQ-002 Remaining ports, one per line (name  direction  width  meaning):
- ireq  out  1  instruction fetch request.
- iack  in  1  fetch accept; irdata is valid in the same cycle.
- irdata  in  32  fetched instruction.
- instout  out  32  latched instruction register (IR); drives im_generator instin.
- imgsel  out  3  immediate format select to im_generator: 000 I, 001 S, 010 B, 011 U, 100 J.
- dmreq  out  1  data memory request.
- dmack  in  1  data memory accept.
- memread  out  1  load access qualifier.
- memwrite  out  1  store access qualifier.
- regwrite  out  1  register file write strobe.
- wbsel  out  2  writeback source: 00 ALU, 01 memory, 10 pc+4.
- brtaken  in  1  branch compare result from the ALU, valid in EXEC.
- pcwrite  out  1  PC update strobe.
- pcsel  out  2  next-PC source: 00 pc+4, 01 pc+imm, 10 ALU (jalr).
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  count of retired instructions.
- state  out  3  current state, for debug.
- err  out  1  sticky illegal-opcode flag.
REQ-003 No parameters.

Function
REQ-004 State encoding SHALL be FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, ERR=111.
REQ-005 ireq SHALL equal (state==FETCH) AND rstn.
REQ-006 In FETCH, when iack=1, the block SHALL load IR from irdata and move to DECODE on the next edge; ireq SHALL be 0 from that next cycle.
REQ-007 iack SHALL be ignored in all states other than FETCH; dmack SHALL be ignored in all states other than MEM.
REQ-008 DECODE SHALL last one cycle and SHALL register imgsel from IR[6:0]:
- 0010011, 0000011, 1100111 -> 000
- 0100011 -> 001
- 1100011 -> 010
- 0110111, 0010111 -> 011
- 1101111 -> 100
- 0110011 -> 000
REQ-009 imgsel SHALL hold its value from the cycle after DECODE until the next DECODE.
REQ-010 Any opcode not listed in REQ-008 SHALL take DECODE->ERR; ERR SHALL set err=1, hold every strobe at 0, and be left only by reset.
REQ-011 EXEC SHALL last one cycle. Next state:
- load, store -> MEM
- branch -> FETCH
- all other listed opcodes -> WB
REQ-012 For a branch in EXEC, the block SHALL assert pcwrite=1, retire=1, and pcsel=01 if brtaken=1 else 00.
REQ-013 MEM SHALL hold dmreq=1, with memread=1 for loads or memwrite=1 for stores, until dmack=1 is sampled.
REQ-014 On MEM accept, a load SHALL go to WB; a store SHALL assert pcwrite=1, pcsel=00, retire=1 in that cycle and go to FETCH.
REQ-015 WB SHALL last one cycle with regwrite=1, pcwrite=1, retire=1, then go to FETCH.
- wbsel=01 for loads; 10 for jal and jalr; 00 otherwise.
- pcsel=01 for jal; 10 for jalr; 00 otherwise.
REQ-016 regwrite, pcwrite and retire SHALL each be asserted for exactly one cycle per instruction, and never in FETCH or DECODE.
REQ-017 instret SHALL increment by 1 on each retire and wrap from 0xFFFFFFFF to 0x00000000.
REQ-018 Strobe outputs SHALL be decoded from state and IR only; no combinational path from iack/dmack to any output other than via state is permitted, except the MEM-accept strobes of REQ-014.

Reset
REQ-019 While rstn=0, regardless of the current state or any pending handshake, the block SHALL immediately drive:
- state=FETCH, IR=0, imgsel=000, instret=0, err=0.
- all strobes 0, dmreq=0, ireq=0.
REQ-020 The first cycle with rstn=1 SHALL assert ireq=1.

Verification
REQ-021 addi 0x00500093, iack on the 3rd FETCH cycle -> imgsel=000; regwrite, pcwrite (pcsel=00), retire 3 cycles after accept; instret=1.
REQ-022 sw 0x0020A423, dmack after 2 MEM cycles -> imgsel=001; memwrite and dmreq high 3 cycles; retire on the dmack cycle; regwrite never 1.
REQ-023 beq 0x00000463 with brtaken=1 -> imgsel=010; pcwrite=1 with pcsel=01 in EXEC; next cycle FETCH.
REQ-024 jal 0x010000EF -> imgsel=100, WB wbsel=10, pcsel=01. Then lui 0x000120B7 -> imgsel=011.
REQ-025 Illegal 0xFFFFFFFF -> ERR, err=1, ireq=0 for 100 cycles; rstn pulse -> FETCH, err=0.
REQ-026 Two cases:
- rstn low mid-MEM (dmreq=1) -> dmreq=0 asynchronously, instret=0.
- Forced instret=0xFFFFFFFF, one retire -> instret=0.
